// File: rtl/ifft8_pkg.sv
// Shared types, default widths and the inverse-twiddle table for the 8-point IFFT core.
package ifft8_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int TW_SCALE_DEF = 1000;
  localparam int TW_W         = 11;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // W^-k = cos + j*sin, scaled by 1000; only k = 0..3 is ever addressed
  function automatic logic signed [TW_W-1:0] tw_re(input logic [1:0] k);
    logic signed [TW_W-1:0] w;
    case (k)
      2'd0:    w = 11'sd1000;
      2'd1:    w = 11'sd707;
      2'd2:    w = 11'sd0;
      default: w = -11'sd707;
    endcase
    return w;
  endfunction

  function automatic logic signed [TW_W-1:0] tw_im(input logic [1:0] k);
    logic signed [TW_W-1:0] w;
    case (k)
      2'd0:    w = 11'sd0;
      2'd1:    w = 11'sd707;
      2'd2:    w = 11'sd1000;
      default: w = 11'sd707;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ifft8_butterfly.sv
// Combinational radix-2 DIT butterfly: t = B*W/scale (truncating), A' = A+t, B' = A-t.
// IFFT8_STAGE_SCALE_EN halves both results (arithmetic shift, floor).
module ifft8_butterfly
  import ifft8_pkg::*;
#(
  parameter int IW       = 19,
  parameter int PW       = 43,
  parameter int TW_SCALE = 1000
) (
  input  logic signed [IW-1:0]   a_re,
  input  logic signed [IW-1:0]   a_im,
  input  logic signed [IW-1:0]   b_re,
  input  logic signed [IW-1:0]   b_im,
  input  logic signed [TW_W-1:0] w_re,
  input  logic signed [TW_W-1:0] w_im,
  output logic signed [IW-1:0]   y0_re,
  output logic signed [IW-1:0]   y0_im,
  output logic signed [IW-1:0]   y1_re,
  output logic signed [IW-1:0]   y1_im
);

  localparam logic signed [PW-1:0] SCALE = PW'(TW_SCALE);

  logic signed [PW-1:0] p_re, p_im, q_re, q_im;
  logic signed [IW-1:0] t_re, t_im, s0_re, s0_im, s1_re, s1_im;

  always_comb begin
    p_re  = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im  = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    q_re  = p_re / SCALE;
    q_im  = p_im / SCALE;
    t_re  = IW'(q_re);
    t_im  = IW'(q_im);
    s0_re = a_re + t_re;
    s0_im = a_im + t_im;
    s1_re = a_re - t_re;
    s1_im = a_im - t_im;
`ifdef IFFT8_STAGE_SCALE_EN
    y0_re = s0_re >>> 1;
    y0_im = s0_im >>> 1;
    y1_re = s1_re >>> 1;
    y1_im = s1_im >>> 1;
`else
    y0_re = s0_re;
    y0_im = s0_im;
    y1_re = s1_re;
    y1_im = s1_im;
`endif
  end

endmodule

// File: rtl/ifft8_core.sv
// Sequential 8-point inverse FFT: load in natural order, 12 in-place butterflies, stream out saturated.
// Per-stage halving is selected by the IFFT8_STAGE_SCALE_EN macro (see ifft8_butterfly).
//   state   | meaning
//   LOAD    | accept 8 samples into RAM at bit-reversed addresses
//   COMPUTE | 3 stages x 4 butterflies, one per cycle, in place
//   UNLOAD  | stream RAM[0..7] with valid/ready, saturated to DATA_W
module ifft8_core
  import ifft8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TW_SCALE = TW_SCALE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     busy
);

  localparam int IW = DATA_W + 3;
  localparam int PW = 2 * DATA_W + 11;
  localparam logic signed [IW-1:0] SAT_MAX = IW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(2 ** (DATA_W - 1)));

  state_t               state;
  logic signed [IW-1:0] mem_re [8];
  logic signed [IW-1:0] mem_im [8];
  logic [2:0]           cnt;
  logic [1:0]           stage, bfly;
  logic [2:0]           pa, pb;
  logic [1:0]           tw_k;
  logic signed [IW-1:0] y0_re, y0_im, y1_re, y1_im;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_MAX) return DATA_W'(SAT_MAX);
    if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    return DATA_W'(v);
  endfunction

  // pair base p = group*2*span + pos, twiddle k = pos << (2-stage)
  always_comb begin
    pa   = '0;
    tw_k = '0;
    case (stage)
      2'd0:    begin pa = {bfly, 1'b0};             tw_k = 2'd0;           end
      2'd1:    begin pa = {bfly[1], 1'b0, bfly[0]}; tw_k = {bfly[0], 1'b0}; end
      default: begin pa = {1'b0, bfly};             tw_k = bfly;           end
    endcase
    pb = pa | (3'd1 << stage);
  end

  ifft8_butterfly #(.IW(IW), .PW(PW), .TW_SCALE(TW_SCALE)) u_bfly (
    .a_re (mem_re[pa]),
    .a_im (mem_im[pa]),
    .b_re (mem_re[pb]),
    .b_im (mem_im[pb]),
    .w_re (tw_re(tw_k)),
    .w_im (tw_im(tw_k)),
    .y0_re(y0_re),
    .y0_im(y0_im),
    .y1_re(y1_re),
    .y1_im(y1_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      stage     <= '0;
      bfly      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem_re[bitrev3(cnt)] <= IW'(in_re);
            mem_im[bitrev3(cnt)] <= IW'(in_im);
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          mem_re[pa] <= y0_re;
          mem_im[pa] <= y0_im;
          mem_re[pb] <= y1_re;
          mem_im[pb] <= y1_im;
          bfly <= bfly + 2'd1;
          if (bfly == 2'd3) begin
            stage <= stage + 2'd1;
            if (stage == 2'd2) begin
              stage <= '0;
              state <= UNLOAD;
            end
          end
        end
        UNLOAD: begin
          // cnt wraps to 0 once sample 7 is presented, marking the final transfer
          if (!out_valid || out_ready) begin
            if (out_valid && cnt == 3'd0) begin
              out_valid <= 1'b0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_re    <= sat(mem_re[cnt]);
              out_im    <= sat(mem_im[cnt]);
              out_valid <= 1'b1;
              cnt       <= cnt + 3'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_core.sv
// Bench for ifft8_core: direct-DFT reference model, per-transfer compare, stall/abort/latency checks.
`timescale 1ns/1ps
module tb_ifft8_core;

  localparam int DW = 16;
  localparam int TWR [8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
  localparam int TWI [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};
`ifdef IFFT8_STAGE_SCALE_EN
  localparam int DIV = 8000;
`else
  localparam int DIV = 1000;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [DW-1:0] in_re, in_im, out_re, out_im;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fx_re [8];
  int fx_im [8];
  int exp_re [$];
  int exp_im [$];
  int cap_re [8];
  int cap_im [8];
  int xfer_cnt = 0;
  int edge_cnt = 0;
  int load0_edge = 0;
  int first_valid_edge = 0;
  bit seen_valid = 0;
  bit hold_pend = 0;
  int hold_re, hold_im, er, ei;

  always #5 clk = ~clk;

  ifft8_core dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int req, input int tol);
    chk_cnt++;
    if (act - req <= tol && req - act <= tol) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rnd_div(input int s);
    real r;
    r = real'(s) / real'(DIV);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  // x[n] = sum_k X[k] * e^{+j*2*pi*k*n/8}, scaled, rounded and saturated
  task automatic model_push();
    int sr, si, m;
    for (int n = 0; n < 8; n++) begin
      sr = 0;
      si = 0;
      for (int k = 0; k < 8; k++) begin
        m  = (k * n) % 8;
        sr += fx_re[k] * TWR[m] - fx_im[k] * TWI[m];
        si += fx_re[k] * TWI[m] + fx_im[k] * TWR[m];
      end
      exp_re.push_back(sat16(rnd_div(sr)));
      exp_im.push_back(sat16(rnd_div(si)));
    end
  endtask

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1, 0);
        check("hold_re", int'(out_re), hold_re, 0);
        check("hold_im", int'(out_im), hold_im, 0);
      end
      hold_pend = 0;
      if (out_valid) begin
        check("busy_unload", int'(busy), 1, 0);
        if (!seen_valid) begin
          seen_valid = 1;
          first_valid_edge = edge_cnt;
        end
        if (out_ready) begin
          if (exp_re.size() == 0) begin
            check("extra_output", 1, 0, 0);
          end else begin
            er = exp_re.pop_front();
            ei = exp_im.pop_front();
            check("out_re", int'(out_re), er, 2);
            check("out_im", int'(out_im), ei, 2);
          end
          if (xfer_cnt < 8) begin
            cap_re[xfer_cnt] = int'(out_re);
            cap_im[xfer_cnt] = int'(out_im);
          end
          xfer_cnt++;
        end else begin
          hold_pend = 1;
          hold_re = int'(out_re);
          hold_im = int'(out_im);
        end
      end
    end
  end

  task automatic set_frame(input int re0, input int im0, input int re_all, input int idx, input int re_i);
    for (int i = 0; i < 8; i++) begin
      fx_re[i] = re_all;
      fx_im[i] = 0;
    end
    fx_re[0] = fx_re[0] + re0;
    fx_im[0] = im0;
    fx_re[idx] = fx_re[idx] + re_i;
  endtask

  task automatic send_frame(input int pulses);
    for (int i = 0; i < 8; i++) begin
      check("in_ready_load", int'(in_ready), 1, 0);
      in_valid = 1'b1;
      in_re = DW'(fx_re[i]);
      in_im = DW'(fx_im[i]);
      @(posedge clk); #1;
      if (i == 0) load0_edge = edge_cnt;
    end
    in_valid = 1'b0;
    check("in_ready_compute", int'(in_ready), 0, 0);
    check("busy_compute", int'(busy), 1, 0);
    for (int c = 0; c < pulses; c++) begin
      in_valid = ~in_valid;
      in_re = 16'sh1234;
      in_im = -16'sh0777;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int stall_at);
    int guard;
    bit stalled;
    guard = 0;
    stalled = 0;
    out_ready = 1'b1;
    while (xfer_cnt < 8 && guard < 200) begin
      if (!stalled && xfer_cnt == stall_at && out_valid) begin
        stalled = 1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_count"}, xfer_cnt, 8, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_extra"}, xfer_cnt, 8, 0);
    check({tag, "_in_ready_after"}, int'(in_ready), 1, 0);
    check({tag, "_busy_after"}, int'(busy), 0, 0);
  endtask

  task automatic run_frame(input string tag, input int pulses, input int stall_at);
    xfer_cnt = 0;
    seen_valid = 0;
    model_push();
    send_frame(pulses);
    drain(tag, stall_at);
    check({tag, "_latency"}, first_valid_edge - load0_edge + 1, 21, 0);
  endtask

  task automatic set_mixed();
    set_frame(400, -200, 0, 0, 0);
    fx_im[2] = 800;
    fx_im[3] = -800;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_out_re", int'(out_re), 0, 0);
    check("rst_out_im", int'(out_im), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef IFFT8_STAGE_SCALE_EN
    set_frame(1000, 0, 0, 0, 0);
    run_frame("impulse", 0, 99);
    check("impulse_x3_re", cap_re[3], 125, 2);
    check("impulse_x3_im", cap_im[3], 0, 2);
    check("impulse_x0_re", cap_re[0], 125, 2);

    set_frame(0, 0, 800, 0, 0);
    run_frame("dc", 0, 99);
    check("dc_x0_re", cap_re[0], 800, 2);
    check("dc_x5_re", cap_re[5], 0, 2);
    check("dc_x5_im", cap_im[5], 0, 2);

    set_frame(0, 0, 0, 1, 8000);
    run_frame("tone", 0, 99);
    check("tone_x1_re", cap_re[1], 707, 2);
    check("tone_x1_im", cap_im[1], 707, 2);
    check("tone_x6_im", cap_im[6], -1000, 2);

    set_mixed();
    run_frame("mixed_stall", 6, 3);
    check("mixed_x0_re", cap_re[0], 50, 2);
    check("mixed_x0_im", cap_im[0], -25, 2);
`else
    set_frame(1000, 0, 0, 0, 0);
    run_frame("impulse", 0, 99);
    check("impulse_x3_re", cap_re[3], 1000, 2);
    check("impulse_x3_im", cap_im[3], 0, 2);

    set_frame(0, 0, 8000, 0, 0);
    run_frame("sat_pos", 0, 99);
    check("sat_pos_x0_re", cap_re[0], 32767, 0);
    check("sat_pos_x4_re", cap_re[4], 0, 2);
    check("sat_pos_x4_im", cap_im[4], 0, 2);

    set_frame(0, 0, -8000, 0, 0);
    run_frame("sat_neg", 0, 99);
    check("sat_neg_x0_re", cap_re[0], -32768, 0);

    set_frame(0, 0, 0, 1, 1000);
    run_frame("tone", 0, 99);
    check("tone_x1_re", cap_re[1], 707, 2);
    check("tone_x1_im", cap_im[1], 707, 2);
    check("tone_x7_im", cap_im[7], -707, 2);

    set_mixed();
    run_frame("mixed_stall", 6, 3);
    check("mixed_x0_re", cap_re[0], 400, 2);
    check("mixed_x0_im", cap_im[0], -200, 2);
`endif

    set_frame(0, 0, 0, 0, 0);
    fx_re[4] = 3000;
    xfer_cnt = 0;
    send_frame(0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", int'(in_ready), 1, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_out_valid", int'(out_valid), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_output", xfer_cnt, 0, 0);

`ifdef IFFT8_STAGE_SCALE_EN
    set_frame(0, 0, 0, 1, 8000);
    run_frame("post_rst", 0, 99);
    check("post_rst_x2_re", cap_re[2], 0, 2);
    check("post_rst_x2_im", cap_im[2], 1000, 2);
`else
    set_frame(0, 0, 0, 1, 1000);
    run_frame("post_rst", 0, 99);
    check("post_rst_x2_re", cap_re[2], 0, 2);
    check("post_rst_x2_im", cap_im[2], 1000, 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
